// File: rtl/plab3_mem_line_mem_responder.sv
`timescale 1ns/1ps
// Line-granular memory responder: one memreq at a time, memresp after p_latency cycles.
// Define PLAB3_MEM_LINE_RESP_OVERLAP_EN to accept a new request on the response handshake edge.
module plab3_mem_line_mem_responder #(
   parameter int p_opaque_nbits = 8,
   parameter int p_mem_nbytes   = 4096,
   parameter int p_latency      = 2,
   parameter int abw            = 32,
   parameter int clw            = 128,
   localparam int lw            = $clog2(clw/8),
   localparam int req_nbits     = 3 + p_opaque_nbits + abw + lw + clw,
   localparam int resp_nbits    = 3 + p_opaque_nbits + lw + clw,
   localparam int nlines        = p_mem_nbytes*8/clw
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memreq_val,
   output logic                  memreq_rdy,
   input  logic [req_nbits-1:0]  memreq_msg,
   output logic                  memresp_val,
   input  logic                  memresp_rdy,
   output logic [resp_nbits-1:0] memresp_msg,
   input  logic                  sd
);
   // state | meaning
   // IDLE  | ready for a request
   // WAIT  | counting down latency
   // RESP  | response valid, waiting for memresp_rdy
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int idx_w  = $clog2(nlines);
   localparam int addr_hi = $clog2(p_mem_nbytes) - 1;
   localparam int cnt_w  = (p_latency > 1) ? $clog2(p_latency) : 1;

   state_t state, state_next, load_state;
   logic [cnt_w-1:0]          cnt;
   logic                      req_go;
   logic [2:0]                req_type;
   logic [p_opaque_nbits-1:0] req_opaque;
   logic [abw-1:0]            req_addr;
   logic [lw-1:0]             req_len;
   logic [clw-1:0]            req_data;
   logic [idx_w-1:0]          idx;
   logic [2:0]                resp_type;
   logic [p_opaque_nbits-1:0] resp_opaque;
   logic [lw-1:0]             resp_len;
   logic [clw-1:0]            resp_data;
   logic [clw-1:0]            mem [nlines];
   logic                      unused_bits;

   assign req_type   = memreq_msg[req_nbits-1 -: 3];
   assign req_opaque = memreq_msg[req_nbits-4 -: p_opaque_nbits];
   assign req_addr   = memreq_msg[clw+lw +: abw];
   assign req_len    = memreq_msg[clw +: lw];
   assign req_data   = memreq_msg[clw-1:0];
   assign idx        = req_addr[addr_hi:lw];
   assign req_go     = memreq_val && memreq_rdy;
   assign load_state = (p_latency == 1) ? RESP : WAIT;
   assign unused_bits = ^{sd, req_addr[abw-1:addr_hi+1], req_addr[lw-1:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_go) state_next = load_state;
         WAIT: if (cnt == cnt_w'(1)) state_next = RESP;
         RESP: if (memresp_rdy) state_next = req_go ? load_state : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      memreq_rdy  = 1'b0;
      memresp_val = 1'b0;
      case (state)
         IDLE: memreq_rdy = reset;
         RESP: begin
            memresp_val = 1'b1;
`ifdef PLAB3_MEM_LINE_RESP_OVERLAP_EN
            memreq_rdy  = memresp_rdy;
`else
            memreq_rdy  = 1'b0;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         resp_type   <= '0;
         resp_opaque <= '0;
         resp_len    <= '0;
         resp_data   <= '0;
      end else if (req_go) begin
         cnt         <= cnt_w'(p_latency - 1);
         resp_type   <= req_type;
         resp_opaque <= req_opaque;
         resp_len    <= req_len;
         resp_data   <= (req_type == 3'd0) ? mem[idx] : '0;
      end else if (state == WAIT) begin
         cnt <= cnt - cnt_w'(1);
      end
   end

   // Array is deliberately left out of reset so contents survive an aborted transaction.
   always_ff @(posedge clk) begin
      if (req_go && (req_type == 3'd1 || req_type == 3'd2)) begin
         for (int b = 0; b < clw/8; b++) begin
            if (req_len == '0 || lw'(b) < req_len)
               mem[idx][b*8 +: 8] <= req_data[b*8 +: 8];
         end
      end
   end

   assign memresp_msg = {resp_type, resp_opaque, resp_len, resp_data};

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
`timescale 1ns/1ps
// Directed bench for plab3_mem_line_mem_responder: vector table plus backpressure,
// reset-abort and back-to-back throughput sequences.
module tb_plab3_mem_line_mem_responder;

   typedef struct {
      logic [2:0]   typ;
      logic [7:0]   op;
      logic [31:0]  addr;
      logic [3:0]   len;
      logic [127:0] data;
      logic [127:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         memreq_val = 1'b0, memreq_rdy;
   logic [174:0] memreq_msg = '0;
   logic         memresp_val, memresp_rdy = 1'b1;
   logic [142:0] memresp_msg;
   logic         req_val1 = 1'b0, req_rdy1;
   logic [174:0] req_msg1 = '0;
   logic         resp_val1, resp_rdy1 = 1'b1;
   logic [142:0] resp_msg1;
   logic         sd = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   vec_t vecs[11];

   always #5 clk = ~clk;

   plab3_mem_line_mem_responder #(.p_latency(2)) dut (
      .clk(clk), .reset(reset),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
      .sd(sd));

   plab3_mem_line_mem_responder #(.p_latency(1)) dut1 (
      .clk(clk), .reset(reset),
      .memreq_val(req_val1), .memreq_rdy(req_rdy1), .memreq_msg(req_msg1),
      .memresp_val(resp_val1), .memresp_rdy(resp_rdy1), .memresp_msg(resp_msg1),
      .sd(sd));

   task automatic check(input string name, input logic [142:0] act, input logic [142:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                               input logic [3:0] l, input logic [127:0] d, input logic [127:0] e);
      vec_t v;
      v.typ = t; v.op = o; v.addr = a; v.len = l; v.data = d; v.exp = e;
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int cyc;
      memresp_rdy = 1'b1;
      memreq_msg  = {v.typ, v.op, v.addr, v.len, v.data};
      memreq_val  = 1'b1;
      check("req_rdy_idle", 143'(memreq_rdy), 143'(1));
      @(posedge clk); #1;
      memreq_val = 1'b0;
      cyc = 0;
      while (!memresp_val && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 143'(cyc), 143'(1));
      check("resp_msg", memresp_msg, {v.typ, v.op, v.len, v.exp});
`ifdef PLAB3_MEM_LINE_RESP_OVERLAP_EN
      check("req_rdy_resp", 143'(memreq_rdy), 143'(1));
`else
      check("req_rdy_resp", 143'(memreq_rdy), 143'(0));
`endif
      @(posedge clk); #1;
      check("resp_done", 143'(memresp_val), 143'(0));
   endtask

   initial begin
      logic [127:0] d_a, d_cafe, d_80;
      logic [142:0] exp_msg;
      int cyc, idx, nresp, edges;
      logic seen, acc, rsp;

      d_a    = 128'h0123456789ABCDEF0123456789ABCDEF;
      d_cafe = 128'hCAFEF00D0BADC0DE123456789ABCDEF0;
      d_80   = {8'hAA, {15{8'h11}}};
      vecs[0]  = mk(3'd1, 8'h11, 32'h0000_0040, 4'd0,  d_a, '0);
      vecs[1]  = mk(3'd0, 8'h22, 32'h0000_004C, 4'd0,  '0, d_a);
      vecs[2]  = mk(3'd2, 8'h33, 32'h0000_0080, 4'd0,  {16{8'hAA}}, '0);
      vecs[3]  = mk(3'd1, 8'h44, 32'h0000_0080, 4'd4,  {{12{8'h55}}, 32'hDEADBEEF}, '0);
      vecs[4]  = mk(3'd0, 8'h55, 32'h0000_0080, 4'd0,  '0, {{12{8'hAA}}, 32'hDEADBEEF});
      vecs[5]  = mk(3'd1, 8'h66, 32'h0000_1040, 4'd0,  d_cafe, '0);
      vecs[6]  = mk(3'd0, 8'h77, 32'h0000_0040, 4'd0,  '0, d_cafe);
      vecs[7]  = mk(3'd5, 8'h88, 32'h0000_0040, 4'd3,  {16{8'hFF}}, '0);
      vecs[8]  = mk(3'd0, 8'h99, 32'h0000_004F, 4'd0,  '0, d_cafe);
      vecs[9]  = mk(3'd1, 8'hAB, 32'h0000_0080, 4'd15, {16{8'h11}}, '0);
      vecs[10] = mk(3'd0, 8'hCD, 32'h0000_0080, 4'd0,  '0, d_80);

      // reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_rdy", 143'(memreq_rdy), 143'(0));
      check("rst_resp_val", 143'(memresp_val), 143'(0));
      check("rst_resp_msg", memresp_msg, '0);
      reset = 1'b1;
      #1;
      check("rel_req_rdy", 143'(memreq_rdy), 143'(1));
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_txn(vecs[i]);

      // backpressure on a read response
      memresp_rdy = 1'b0;
      memreq_msg  = {3'd0, 8'hE1, 32'h0000_0080, 4'd0, 128'h0};
      memreq_val  = 1'b1;
      @(posedge clk); #1;
      memreq_val = 1'b0;
      cyc = 0;
      while (!memresp_val && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      exp_msg = {3'd0, 8'hE1, 4'd0, d_80};
      for (int i = 0; i < 5; i++) begin
         check("bp_val", 143'(memresp_val), 143'(1));
         check("bp_msg", memresp_msg, exp_msg);
         check("bp_req_rdy", 143'(memreq_rdy), 143'(0));
         @(posedge clk); #1;
      end
      memresp_rdy = 1'b1;
      @(posedge clk); #1;
      check("bp_done_val", 143'(memresp_val), 143'(0));
      check("bp_done_rdy", 143'(memreq_rdy), 143'(1));

      // reset aborts a read in WAIT; array survives
      memreq_msg = {3'd0, 8'hF0, 32'h0000_0040, 4'd0, 128'h0};
      memreq_val = 1'b1;
      @(posedge clk); #1;
      memreq_val = 1'b0;
      reset = 1'b0;
      #1;
      check("abort_req_rdy", 143'(memreq_rdy), 143'(0));
      check("abort_resp_val", 143'(memresp_val), 143'(0));
      check("abort_resp_msg", memresp_msg, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen |= memresp_val;
         @(posedge clk); #1;
      end
      check("abort_no_resp", 143'(seen), 143'(0));
      run_txn(mk(3'd0, 8'hF1, 32'h0000_0040, 4'd0, '0, d_cafe));

      // four back-to-back reads on the single-cycle-latency instance
      idx = 0; nresp = 0; edges = 0;
      resp_rdy1 = 1'b1;
      req_msg1  = {3'd0, 8'h30, 32'h0000_0100, 4'd0, 128'h0};
      req_val1  = 1'b1;
      while (nresp < 4 && edges < 40) begin
         acc = req_val1 & req_rdy1;
         rsp = resp_val1 & resp_rdy1;
         if (rsp) check("ovl_opaque", 143'(resp_msg1[139:132]), 143'(8'h30 + nresp));
         @(posedge clk); #1;
         edges++;
         if (acc) begin
            idx++;
            if (idx < 4) req_msg1 = {3'd0, 8'(8'h30 + idx), 32'h0000_0100 + 32'(idx*16), 4'd0, 128'h0};
            else         req_val1 = 1'b0;
         end
         if (rsp) nresp++;
      end
`ifdef PLAB3_MEM_LINE_RESP_OVERLAP_EN
      check("ovl_cycles", 143'(edges), 143'(5));
`else
      check("ovl_cycles", 143'(edges), 143'(8));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
